// File: rtl/pac_man_pellet_tracker.sv
// Pac-Man pellet tracker: loads the pellet map from ROM, then tracks moves,
// clears eaten pellets and keeps score / pellets-left counters.
//
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   move_tick     - commits next_block as the new position when idle
//   next_block    - candidate position, row*32 + col
//   rom_data      - pellet-map row, valid one cycle after rom_addr
//   rom_addr      - pellet-map row address during init
//   curr_block    - registered Pac-Man position
//   score         - pellets eaten since reset
//   pellets_left  - pellets still on the board
//   eat_pulse     - one-cycle pulse per pellet eaten
//   busy          - map load in progress
//   level_clear   - every pellet eaten; terminal until reset
module pac_man_pellet_tracker #(
    parameter logic [9:0] START_BLOCK = 10'd33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_tick,
    input  logic [9:0]  next_block,
    input  logic [31:0] rom_data,
    output logic [4:0]  rom_addr,
    output logic [9:0]  curr_block,
    output logic [10:0] score,
    output logic [10:0] pellets_left,
    output logic        eat_pulse,
    output logic        busy,
    output logic        level_clear
);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_EAT,
        S_DONE
    } state_t;

    state_t      state;
    logic [5:0]  init_cnt;
    logic [31:0] pellet_map [32];

    logic [4:0]  cur_row;
    logic [4:0]  cur_bit;
    logic        map_bit;
    logic [10:0] init_sum;

    function automatic logic [5:0] popcount(input logic [31:0] w);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, w[i]};
        end
        return c;
    endfunction

    // Init cycle k addresses row k; the low bits wrap to 0 on the
    // final write cycle, where the address is no longer used.
    assign rom_addr    = init_cnt[4:0];
    assign busy        = (state == S_INIT);
    assign level_clear = (state == S_DONE);

    // Column col lives at bit (31 - col), which for 5 bits is ~col.
    assign cur_row  = curr_block[9:5];
    assign cur_bit  = ~curr_block[4:0];
    assign map_bit  = pellet_map[cur_row][cur_bit];
    assign init_sum = pellets_left + {5'd0, popcount(rom_data)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_INIT;
            init_cnt     <= '0;
            curr_block   <= START_BLOCK;
            score        <= '0;
            pellets_left <= '0;
            eat_pulse    <= 1'b0;
        end else begin
            eat_pulse <= 1'b0;
            unique case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 6'd1;
                    // Cycle 0 only issues the first address; data
                    // for row k-1 arrives on cycle k.
                    if (init_cnt != 6'd0) begin
                        pellets_left <= init_sum;
                    end
                    if (init_cnt == 6'd32) begin
                        state <= (init_sum == 11'd0) ? S_DONE : S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (move_tick) begin
                        curr_block <= next_block;
                        state      <= S_EAT;
                    end
                end
                S_EAT: begin
                    if (map_bit) begin
                        score        <= score + 11'd1;
                        pellets_left <= pellets_left - 11'd1;
                        eat_pulse    <= 1'b1;
                        state <= (pellets_left == 11'd1) ? S_DONE : S_IDLE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                end
            endcase
        end
    end

    // Map storage has no reset; the init sequence rewrites every word.
    always_ff @(posedge clk) begin
        if (state == S_INIT && init_cnt != 6'd0) begin
            pellet_map[init_cnt[4:0] - 5'd1] <= rom_data;
        end else if (state == S_EAT && map_bit) begin
            pellet_map[cur_row][cur_bit] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pac_man_pellet_tracker.sv
// Directed testbench for pac_man_pellet_tracker.
// Drives and samples on the falling clock edge.
module tb_pac_man_pellet_tracker;

    logic        clk;
    logic        reset;
    logic        move_tick;
    logic [9:0]  next_block;
    logic [31:0] rom_data;
    logic [4:0]  rom_addr;
    logic [9:0]  curr_block;
    logic [10:0] score;
    logic [10:0] pellets_left;
    logic        eat_pulse;
    logic        busy;
    logic        level_clear;

    logic [31:0] rom [32];
    int tests;
    int failed;
    int cnt;

    pac_man_pellet_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .move_tick    (move_tick),
        .next_block   (next_block),
        .rom_data     (rom_data),
        .rom_addr     (rom_addr),
        .curr_block   (curr_block),
        .score        (score),
        .pellets_left (pellets_left),
        .eat_pulse    (eat_pulse),
        .busy         (busy),
        .level_clear  (level_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_busy();
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        reset      = 1'b1;
        move_tick  = 1'b0;
        next_block = 10'd0;
        for (int i = 0; i < 32; i++) rom[i] = 32'hFFFF_FFFF;
        rom[0] = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_lc", {31'd0, level_clear}, 32'd0);
        check("rst_addr", {27'd0, rom_addr}, 32'd0);
        check("rst_curr", {22'd0, curr_block}, 32'd33);
        check("rst_score", {21'd0, score}, 32'd0);
        check("rst_pl", {21'd0, pellets_left}, 32'd0);
        check("rst_eat", {31'd0, eat_pulse}, 32'd0);

        // Full-board load: 31 rows of 32 pellets.
        reset = 1'b0;
        count_busy();
        check("init_len", cnt, 32'd33);
        check("init_pl", {21'd0, pellets_left}, 32'd992);
        check("init_score", {21'd0, score}, 32'd0);
        check("init_lc", {31'd0, level_clear}, 32'd0);
        check("init_curr", {22'd0, curr_block}, 32'd33);

        // Eat the pellet at cell 34.
        next_block = 10'd34;
        move_tick  = 1'b1;
        @(posedge clk);
        #1;
        check("eat_curr", {22'd0, curr_block}, 32'd34);
        @(negedge clk);
        move_tick = 1'b0;
        check("eat_pre", {31'd0, eat_pulse}, 32'd0);
        @(negedge clk);
        check("eat_score", {21'd0, score}, 32'd1);
        check("eat_pl", {21'd0, pellets_left}, 32'd991);
        check("eat_pulse", {31'd0, eat_pulse}, 32'd1);
        @(negedge clk);
        check("eat_pulse_end", {31'd0, eat_pulse}, 32'd0);

        // Revisit the already-cleared cell.
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        @(negedge clk);
        check("rev_score", {21'd0, score}, 32'd1);
        check("rev_eat", {31'd0, eat_pulse}, 32'd0);
        check("rev_pl", {21'd0, pellets_left}, 32'd991);

        // Held tick: commits on alternate edges only (100, 102, 104).
        move_tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_block = 10'd100 + 10'(i);
            @(negedge clk);
        end
        move_tick = 1'b0;
        check("hold_curr", {22'd0, curr_block}, 32'd104);
        check("hold_score", {21'd0, score}, 32'd4);
        check("hold_pl", {21'd0, pellets_left}, 32'd988);

        // Reload with ticks held high through init.
        reset = 1'b1;
        @(negedge clk);
        move_tick  = 1'b1;
        next_block = 10'd500;
        reset      = 1'b0;
        repeat (10) @(negedge clk);
        check("init_tick_curr", {22'd0, curr_block}, 32'd33);
        check("init_tick_busy", {31'd0, busy}, 32'd1);
        check("mid_pl_nonzero", {31'd0, 1'(pellets_left != 0)}, 32'd1);

        // Abort mid-init; reset acts without waiting for a clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("abort_pl", {21'd0, pellets_left}, 32'd0);
        check("abort_addr", {27'd0, rom_addr}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd1);
        check("abort_curr", {22'd0, curr_block}, 32'd33);
        move_tick = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 32'h0;
        rom[1] = 32'h0080_0000;
        @(negedge clk);
        reset = 1'b0;
        count_busy();
        check("reload_len", cnt, 32'd33);
        check("reload_pl", {21'd0, pellets_left}, 32'd1);
        check("reload_lc", {31'd0, level_clear}, 32'd0);

        // Eat the only pellet at cell 40.
        next_block = 10'd40;
        move_tick  = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        @(negedge clk);
        check("clr_pl", {21'd0, pellets_left}, 32'd0);
        check("clr_score", {21'd0, score}, 32'd1);
        check("clr_lc", {31'd0, level_clear}, 32'd1);
        check("clr_eat", {31'd0, eat_pulse}, 32'd1);
        next_block = 10'd7;
        move_tick  = 1'b1;
        repeat (4) @(negedge clk);
        move_tick = 1'b0;
        check("done_curr", {22'd0, curr_block}, 32'd40);
        check("done_lc", {31'd0, level_clear}, 32'd1);
        check("done_score", {21'd0, score}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
